regfile_fwd: RTL and testbench
==============================

REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 SHALL provide parameters, one per line:
 - WIDTH, 32, data bits per register
 - ADDR_W, 5, register address bits (DEPTH = 2**ADDR_W)
 - NRD, 2, number of read ports
 - CNT_W, 2, width of per-register in-flight counter
REQ-002 SHALL have ports, one per line (name direction width meaning):
 - Clk  input  1  single clock, rising edge
 - Rst  input  1  synchronous, active-high reset
 - Rd_Addr  input  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
 - Rd_Used  input  NRD  port i operand is consumed by the instruction in D
 - Rd_Tuse  input  NRD*2  cycles until port i operand is needed (0 = in D)
 - Rd_Data  output  NRD*WIDTH  forwarded read data
 - Fwd_En_E / Fwd_En_M  input  1  E/M instruction writes a register
 - Fwd_Addr_E / Fwd_Addr_M  input  ADDR_W  E/M destination register
 - Fwd_Data_E / Fwd_Data_M  input  WIDTH  E/M forwarding value
 - Fwd_Tnew_E / Fwd_Tnew_M  input  2  cycles until E/M value is valid
 - Wr_En  input  1  W-stage commit
 - Wr_Addr  input  ADDR_W  W destination
 - Wr_Data  input  WIDTH  W write data
 - Issue_En  input  1  instruction in D writes a register when it advances
 - Issue_Addr  input  ADDR_W  its destination
 - Stall  output  1  hold F/D, bubble E
 - Pending  output  DEPTH  per-register in-flight flag (counter != 0)
REQ-003 SHALL use one clock Clk and a synchronous active-high reset Rst, both fixed.

Function
REQ-004 SHALL hold DEPTH registers of WIDTH bits; register 0 SHALL read as 0 and ignore writes.
REQ-005 SHALL write Wr_Data to Wr_Addr on the rising edge when Wr_En=1 and Wr_Addr!=0.
REQ-006 Rd_Data port i SHALL be combinational with priority: addr==0 -> 0; E match (Fwd_En_E, Tnew_E==0) -> Fwd_Data_E; M match (Fwd_En_M, Tnew_M==0) -> Fwd_Data_M; W match (Wr_En) -> Wr_Data; else array.
REQ-007 An E or M match with nonzero Tnew SHALL block lower-priority sources; Rd_Data then returns the stale array value and correctness relies on Stall.
REQ-008 Stall SHALL assert when, for any port i with Rd_Used[i]=1 and addr!=0, the youngest matching writer (E before M) has Fwd_Tnew > Rd_Tuse[i].
REQ-009 SHALL keep a CNT_W-bit counter per register counting issued but uncommitted writes.
REQ-010 Counter for Issue_Addr SHALL increment when Issue_En=1, Stall=0, Issue_Addr!=0.
REQ-011 Counter for Wr_Addr SHALL decrement when Wr_En=1, Wr_Addr!=0, counter!=0; decrement at 0 SHALL be ignored (saturate at 0).
REQ-012 Simultaneous increment and decrement on the same register SHALL leave the counter unchanged; increment at maximum SHALL saturate.
REQ-013 Pending[r] SHALL equal (counter[r]!=0); Pending[0] SHALL be constant 0.
REQ-014 Stall SHALL be a function of current inputs only (zero-latency); reads and writes in the same cycle SHALL be write-through per REQ-006.

Reset
REQ-015 On a Clk edge with Rst=1, all registers and all counters SHALL clear to 0; Pending SHALL read 0 the following cycle.
REQ-016 Rst SHALL take priority over a same-cycle write or issue; Rst asserted mid-operation discards all in-flight state.
REQ-017 Rd_Data and Stall have no reset value of their own; after reset with all enables low they SHALL read 0.

Verification
REQ-018 Reset, then Rd_Addr={5,3} with no writers -> Rd_Data={0,0}, Stall=0, Pending=0.
REQ-019 Wr_En=1, Wr_Addr=5, Wr_Data=0x1234 while reading port0=5 -> same cycle Rd_Data0=0x1234; next cycle array returns 0x1234; Wr_Addr=0 -> reg0 stays 0.
REQ-020 Fwd E addr=7 Tnew=0 data=0xAAAA, M addr=7 Tnew=0 data=0xBBBB, read port1=7 -> 0xAAAA (E priority).
REQ-021 Fwd E addr=9 Tnew=2, port0=9, Rd_Used0=1, Tuse=0 -> Stall=1; Tuse=2 -> Stall=0; Rd_Used0=0 -> Stall=0.
REQ-022 Issue addr=4 twice (no stall), commit addr=4 once -> counter 1, Pending[4]=1; issue and commit addr=4 in same cycle -> counter unchanged; second commit -> Pending[4]=0; extra commit -> stays 0.
REQ-023 Issue addr=6 while Stall=1 -> counter unchanged; Rst with counters nonzero -> all Pending 0 next cycle.

Source files
------------

// File: rtl/regfile_fwd_if.sv
// Bus bundle for the forwarding register file: read ports, E/M forwarding,
// W commit, issue tracking and the stall/pending results.
interface regfile_fwd_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NRD*ADDR_W-1:0] Rd_Addr;
    logic [NRD-1:0]        Rd_Used;
    logic [NRD*2-1:0]      Rd_Tuse;
    logic [NRD*WIDTH-1:0]  Rd_Data;

    logic                  Fwd_En_E;
    logic [ADDR_W-1:0]     Fwd_Addr_E;
    logic [WIDTH-1:0]      Fwd_Data_E;
    logic [1:0]            Fwd_Tnew_E;
    logic                  Fwd_En_M;
    logic [ADDR_W-1:0]     Fwd_Addr_M;
    logic [WIDTH-1:0]      Fwd_Data_M;
    logic [1:0]            Fwd_Tnew_M;

    logic                  Wr_En;
    logic [ADDR_W-1:0]     Wr_Addr;
    logic [WIDTH-1:0]      Wr_Data;

    logic                  Issue_En;
    logic [ADDR_W-1:0]     Issue_Addr;

    logic                  Stall;
    logic [DEPTH-1:0]      Pending;

    modport master (
        output Rd_Addr, Rd_Used, Rd_Tuse,
        output Fwd_En_E, Fwd_Addr_E, Fwd_Data_E, Fwd_Tnew_E,
        output Fwd_En_M, Fwd_Addr_M, Fwd_Data_M, Fwd_Tnew_M,
        output Wr_En, Wr_Addr, Wr_Data, Issue_En, Issue_Addr,
        input  Rd_Data, Stall, Pending
    );

    modport slave (
        input  Rd_Addr, Rd_Used, Rd_Tuse,
        input  Fwd_En_E, Fwd_Addr_E, Fwd_Data_E, Fwd_Tnew_E,
        input  Fwd_En_M, Fwd_Addr_M, Fwd_Data_M, Fwd_Tnew_M,
        input  Wr_En, Wr_Addr, Wr_Data, Issue_En, Issue_Addr,
        output Rd_Data, Stall, Pending
    );
endinterface

// File: rtl/regfile_fwd.sv
// Register file with E/M/W operand forwarding, Tnew/Tuse hazard stall and
// per-register in-flight write counters.
module regfile_fwd #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input logic          Clk,
    input logic          Rst,
    regfile_fwd_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem     [DEPTH];
    logic [CNT_W-1:0]  cnt     [DEPTH];
    logic [ADDR_W-1:0] addr    [NRD];
    logic [1:0]        tuse    [NRD];
    logic [WIDTH-1:0]  rd_word [NRD];
    logic              stall;
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;
    logic [DEPTH-1:0]  pending;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        assign addr[i] = bus.Rd_Addr[i*ADDR_W +: ADDR_W];
        assign tuse[i] = bus.Rd_Tuse[i*2 +: 2];
        assign bus.Rd_Data[i*WIDTH +: WIDTH] = rd_word[i];
    end

    // A matching E/M writer whose value is not ready yet still owns the read,
    // so older sources are masked and the stale array value leaks through.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_word = '{default: '0};
        stall   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (addr[i] == '0) begin
                rd_word[i] = '0;
            end else if (bus.Fwd_En_E && bus.Fwd_Addr_E == addr[i]) begin
                rd_word[i] = (bus.Fwd_Tnew_E == 2'd0) ? bus.Fwd_Data_E : mem[addr[i]];
                if (bus.Rd_Used[i] && bus.Fwd_Tnew_E > tuse[i]) stall = 1'b1;
            end else if (bus.Fwd_En_M && bus.Fwd_Addr_M == addr[i]) begin
                rd_word[i] = (bus.Fwd_Tnew_M == 2'd0) ? bus.Fwd_Data_M : mem[addr[i]];
                if (bus.Rd_Used[i] && bus.Fwd_Tnew_M > tuse[i]) stall = 1'b1;
            end else if (bus.Wr_En && bus.Wr_Addr == addr[i]) begin
                rd_word[i] = bus.Wr_Data;
            end else begin
                rd_word[i] = mem[addr[i]];
            end
        end
    end

    assign bus.Stall = stall;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (bus.Issue_En && !stall && bus.Issue_Addr != '0)
            inc_vec[bus.Issue_Addr] = 1'b1;
        if (bus.Wr_En && bus.Wr_Addr != '0 && cnt[bus.Wr_Addr] != '0)
            dec_vec[bus.Wr_Addr] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        // NOTE: the array is reset because cleared registers must read 0 after Rst.
        if (Rst) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (bus.Wr_En && bus.Wr_Addr != '0) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            mem[bus.Wr_Addr] <= bus.Wr_Data;
        end
    end

    // Increment saturates at all-ones; decrement is already gated off at zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (inc_vec[r] && !dec_vec[r] && cnt[r] != '1)
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < DEPTH; r++) pending[r] = (cnt[r] != '0);
    end

    assign bus.Pending = pending;
endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: reset, write-through, forwarding priority,
// hazard stall and in-flight counter tracking.
module tb_regfile_fwd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_fwd_if #(.WIDTH(32), .ADDR_W(5), .NRD(2)) bus ();

    regfile_fwd #(.WIDTH(32), .ADDR_W(5), .NRD(2), .CNT_W(2)) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    task automatic idle();
        bus.Rd_Addr    = '0;
        bus.Rd_Used    = '0;
        bus.Rd_Tuse    = '0;
        bus.Fwd_En_E   = 1'b0;
        bus.Fwd_Addr_E = '0;
        bus.Fwd_Data_E = '0;
        bus.Fwd_Tnew_E = '0;
        bus.Fwd_En_M   = 1'b0;
        bus.Fwd_Addr_M = '0;
        bus.Fwd_Data_M = '0;
        bus.Fwd_Tnew_M = '0;
        bus.Wr_En      = 1'b0;
        bus.Wr_Addr    = '0;
        bus.Wr_Data    = '0;
        bus.Issue_En   = 1'b0;
        bus.Issue_Addr = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_rd(input string name, input int port, input logic [31:0] want);
        logic [31:0] got;
        #1;
        got = (port == 0) ? bus.Rd_Data[31:0] : bus.Rd_Data[63:32];
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: Rd_Data%0d got %h expected %h", name, port, got, want);
        end
    endtask

    task automatic cmp_stall(input string name, input logic want);
        #1;
        n_cmp++;
        if (bus.Stall !== want) begin
            n_bad++;
            $display("FAIL %s: Stall got %b expected %b", name, bus.Stall, want);
        end
    endtask

    task automatic cmp_pend(input string name, input logic [31:0] want);
        #1;
        n_cmp++;
        if (bus.Pending !== want) begin
            n_bad++;
            $display("FAIL %s: Pending got %h expected %h", name, bus.Pending, want);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.Rd_Addr = {5'd5, 5'd3};
        cmp_rd("reset_rd0", 0, 32'h0);
        cmp_rd("reset_rd1", 1, 32'h0);
        cmp_stall("reset_stall", 1'b0);
        cmp_pend("reset_pending", 32'h0);
    endtask

    task automatic test_write_through();
        idle();
        bus.Rd_Addr = {5'd0, 5'd5};
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = 5'd5;
        bus.Wr_Data = 32'h1234;
        cmp_rd("wt_same_cycle", 0, 32'h1234);
        tick();
        bus.Wr_En = 1'b0;
        cmp_rd("wt_array", 0, 32'h1234);
        // Register 0 ignores writes, including the write-through path.
        bus.Rd_Addr = {5'd0, 5'd0};
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = 5'd0;
        bus.Wr_Data = 32'hFFFF;
        cmp_rd("wt_r0_same", 0, 32'h0);
        tick();
        bus.Wr_En = 1'b0;
        cmp_rd("wt_r0_after", 0, 32'h0);
        // Unready E writer masks a W write to the same register: stale value.
        bus.Rd_Addr    = {5'd0, 5'd5};
        bus.Fwd_En_E   = 1'b1;
        bus.Fwd_Addr_E = 5'd5;
        bus.Fwd_Tnew_E = 2'd1;
        bus.Fwd_Data_E = 32'h9999;
        bus.Wr_En      = 1'b1;
        bus.Wr_Addr    = 5'd5;
        bus.Wr_Data    = 32'h5555;
        cmp_rd("wt_blocked_stale", 0, 32'h1234);
        bus.Wr_En = 1'b0;
        tick();
    endtask

    task automatic test_fwd_priority();
        idle();
        bus.Rd_Addr    = {5'd7, 5'd0};
        bus.Fwd_En_E   = 1'b1;
        bus.Fwd_Addr_E = 5'd7;
        bus.Fwd_Data_E = 32'hAAAA;
        bus.Fwd_En_M   = 1'b1;
        bus.Fwd_Addr_M = 5'd7;
        bus.Fwd_Data_M = 32'hBBBB;
        cmp_rd("fwd_e_priority", 1, 32'hAAAA);
        bus.Fwd_En_E = 1'b0;
        cmp_rd("fwd_m", 1, 32'hBBBB);
        bus.Fwd_Tnew_M = 2'd1;
        bus.Wr_En      = 1'b1;
        bus.Wr_Addr    = 5'd7;
        bus.Wr_Data    = 32'hCCCC;
        cmp_rd("fwd_m_blocks_w", 1, 32'h0);
        bus.Fwd_En_M = 1'b0;
        cmp_rd("fwd_w", 1, 32'hCCCC);
        idle();
        tick();
    endtask

    task automatic test_stall();
        idle();
        bus.Rd_Addr    = {5'd0, 5'd9};
        bus.Rd_Used    = 2'b01;
        bus.Fwd_En_E   = 1'b1;
        bus.Fwd_Addr_E = 5'd9;
        bus.Fwd_Tnew_E = 2'd2;
        cmp_stall("stall_tuse0", 1'b1);
        bus.Rd_Tuse = {2'd0, 2'd2};
        cmp_stall("stall_tuse2", 1'b0);
        bus.Rd_Tuse = '0;
        bus.Rd_Used = 2'b00;
        cmp_stall("stall_unused", 1'b0);
        // The youngest writer decides: a ready E hides an unready M.
        bus.Rd_Used    = 2'b01;
        bus.Fwd_Tnew_E = 2'd0;
        bus.Fwd_En_M   = 1'b1;
        bus.Fwd_Addr_M = 5'd9;
        bus.Fwd_Tnew_M = 2'd2;
        cmp_stall("stall_e_hides_m", 1'b0);
        bus.Fwd_En_E = 1'b0;
        cmp_stall("stall_from_m", 1'b1);
        idle();
    endtask

    task automatic test_counters();
        idle();
        bus.Issue_En   = 1'b1;
        bus.Issue_Addr = 5'd4;
        tick();
        tick();
        bus.Issue_En = 1'b0;
        cmp_pend("cnt_issue2", 32'h10);
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = 5'd4;
        bus.Wr_Data = 32'h44;
        tick();
        cmp_pend("cnt_commit1", 32'h10);
        bus.Issue_En = 1'b1;
        tick();
        bus.Issue_En = 1'b0;
        cmp_pend("cnt_same_cycle", 32'h10);
        tick();
        cmp_pend("cnt_commit2", 32'h0);
        tick();
        bus.Wr_En = 1'b0;
        cmp_pend("cnt_extra_commit", 32'h0);
        // Four issues saturate at 3, so three commits are needed to drain.
        bus.Issue_En = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.Issue_En = 1'b0;
        bus.Wr_En    = 1'b1;
        tick();
        tick();
        cmp_pend("cnt_sat_two_commits", 32'h10);
        tick();
        bus.Wr_En = 1'b0;
        cmp_pend("cnt_sat_drained", 32'h0);
    endtask

    task automatic test_stall_issue_reset();
        idle();
        bus.Rd_Addr    = {5'd0, 5'd9};
        bus.Rd_Used    = 2'b01;
        bus.Fwd_En_E   = 1'b1;
        bus.Fwd_Addr_E = 5'd9;
        bus.Fwd_Tnew_E = 2'd2;
        bus.Issue_En   = 1'b1;
        bus.Issue_Addr = 5'd6;
        cmp_stall("issue_stall_active", 1'b1);
        tick();
        cmp_pend("issue_while_stall", 32'h0);
        bus.Fwd_En_E = 1'b0;
        tick();
        cmp_pend("issue_no_stall", 32'h40);
        // Rst wins over a same-cycle issue and write.
        rst         = 1'b1;
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = 5'd5;
        bus.Wr_Data = 32'h7777;
        tick();
        rst = 1'b0;
        idle();
        bus.Rd_Addr = {5'd7, 5'd5};
        cmp_pend("rst_pending", 32'h0);
        cmp_rd("rst_reg5", 0, 32'h0);
        cmp_rd("rst_reg7", 1, 32'h0);
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_write_through();
        test_fwd_priority();
        test_stall();
        test_counters();
        test_stall_issue_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
